// File: rtl/uart_rx_fifo.sv
// 8N1 serial receiver with mid-bit sampling feeding a small show-ahead FIFO (valid/ready read side).
// Define UART_RX_PARITY_EN to receive 8E1 frames and drive parity_err; otherwise parity_err is tied 0.
//
// state   | meaning
// IDLE    | line idle, waiting for a falling edge (only after a high level has been seen)
// START   | counting to the start-bit centre, rejecting glitches
// DATA    | sampling 8 data bits LSB first at bit centres
// PARITY  | sampling the even-parity bit (parity build only)
// STOP    | sampling the stop bit; push byte or flag framing error
// BREAK   | line stuck low after a framing error, waiting for it to return high
module uart_rx_fifo #(
    parameter int CLK_DIV = 52,
    parameter int FIFO_AW = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_rx,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    input  logic       rd_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       parity_err
);

    localparam int CW    = $clog2(CLK_DIV);
    localparam int PW    = FIFO_AW + 1;
    localparam int DEPTH = 1 << FIFO_AW;

    localparam logic [CW-1:0] HALF_TC = CW'(CLK_DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_TC = CW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_BREAK
    } state_t;

    logic          sync1_q, sync2_q;
    logic [1:0]    fill_q;
    logic          rxs;
    logic          rxs_real;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_q;
    logic [7:0]    sr_q;
    logic          idle_seen_q;
    logic          frame_err_q;
    logic          overrun_q;
    logic          push;

    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic          empty, full, pop, wr_en, drop;

    // fill_q marks when the synchronizer holds real line samples rather than its reset value,
    // so a line held low through reset cannot set idle_seen from the reset-state ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            fill_q  <= 2'b00;
        end else begin
            sync1_q <= uart_rx;
            sync2_q <= sync1_q;
            fill_q  <= {fill_q[0], 1'b1};
        end
    end

    assign rxs      = sync2_q;
    assign rxs_real = fill_q[1];

`ifdef UART_RX_PARITY_EN
    logic par_bad_q;
    logic parity_err_q;

    assign push       = (state_q == S_STOP) && (cnt_q == FULL_TC) && rxs && !par_bad_q;
    assign parity_err = parity_err_q;
`else
    assign push       = (state_q == S_STOP) && (cnt_q == FULL_TC) && rxs;
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            sr_q         <= '0;
            idle_seen_q  <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            if (rxs && rxs_real) idle_seen_q <= 1'b1;

            case (state_q)
                S_IDLE: begin
                    if (!rxs && idle_seen_q) begin
                        state_q <= S_START;
                        cnt_q   <= '0;
                    end
                end
                S_START: begin
                    if (cnt_q == HALF_TC) begin
                        cnt_q <= '0;
                        bit_q <= '0;
                        state_q <= rxs ? S_IDLE : S_DATA;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_DATA: begin
                    if (cnt_q == FULL_TC) begin
                        cnt_q <= '0;
                        sr_q  <= {rxs, sr_q[7:1]};
                        bit_q <= bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= S_PARITY;
`else
                            state_q <= S_STOP;
`endif
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (cnt_q == FULL_TC) begin
                        cnt_q     <= '0;
                        par_bad_q <= rxs ^ (^sr_q);
                        state_q   <= S_STOP;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
`endif
                S_STOP: begin
                    if (cnt_q == FULL_TC) begin
                        cnt_q <= '0;
                        if (rxs) begin
`ifdef UART_RX_PARITY_EN
                            parity_err_q <= par_bad_q;
`endif
                            state_q <= S_IDLE;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= S_BREAK;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_BREAK: begin
                    if (rxs) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign empty    = (wptr_q == rptr_q);
    assign full     = (wptr_q[FIFO_AW] != rptr_q[FIFO_AW]) &&
                      (wptr_q[FIFO_AW-1:0] == rptr_q[FIFO_AW-1:0]);
    assign rd_valid = !empty;
    assign pop      = rd_valid && rd_ready;
    // A pop frees the head slot in the same cycle, so a full FIFO still accepts a push then.
    assign wr_en    = push && (!full || pop);
    assign drop     = push && full && !pop;
    assign rd_data  = mem_q[rptr_q[FIFO_AW-1:0]];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (wr_en) wptr_d = wptr_q + PW'(1);
        if (pop)   rptr_d = rptr_q + PW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            overrun_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            overrun_q <= drop;
            if (wr_en) mem_q[wptr_q[FIFO_AW-1:0]] <= sr_q;
        end
    end

    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: directed frames, expected bytes queued at send time,
// a negedge monitor pops and compares every accepted byte and counts error pulses.
module tb_uart_rx_fifo;

    localparam int CLK_DIV = 52;
    localparam int FIFO_AW = 2;
`ifdef UART_RX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    // posedge index (from the edge the start bit is launched after) at which the stop bit is sampled
    localparam int PUSH_OFS = 3 + CLK_DIV / 2 + CLK_DIV * (NBITS - 1);

    logic       clk = 1'b0;
    logic       rst_n;
    logic       uart_rx;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_ready;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;

    int checks = 0;
    int errors = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int pe_cnt = 0;
    logic [7:0] exp_q[$];
`ifdef UART_RX_PARITY_EN
    logic par_flip_g = 1'b0;
`endif

    uart_rx_fifo #(.CLK_DIV(CLK_DIV), .FIFO_AW(FIFO_AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .uart_rx    (uart_rx),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_err)  fe_cnt++;
            if (overrun)    ov_cnt++;
            if (parity_err) pe_cnt++;
            if (rd_valid && rd_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pop: got 0x%0h expected no byte", rd_data);
                end else begin
                    chk("rd_data", int'(rd_data), int'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        uart_rx = b;
        repeat (CLK_DIV) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b);
        @(posedge clk);
        #1;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit((^d) ^ par_flip_g);
`endif
        drive_bit(stop_b);
    endtask

    task automatic send_byte(input logic [7:0] d);
        send_frame(d, 1'b1);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 400; i++) begin
            if (exp_q.size() == 0 && !rd_valid) break;
            @(posedge clk);
        end
        #1;
        chk(name, exp_q.size(), 0);
        chk({name, "_valid"}, int'(rd_valid), 0);
    endtask

    initial begin
        uart_rx  = 1'b1;
        rd_ready = 1'b0;
        rst_n    = 1'b0;
        idle(3);
        chk("rst_rd_valid",   int'(rd_valid),   0);
        chk("rst_rd_data",    int'(rd_data),    0);
        chk("rst_frame_err",  int'(frame_err),  0);
        chk("rst_overrun",    int'(overrun),    0);
        chk("rst_parity_err", int'(parity_err), 0);
        rst_n = 1'b1;
        idle(10);

        // T1: two back-to-back bytes, consumer always ready
        rd_ready = 1'b1;
        exp_q.push_back(8'h2B);
        send_byte(8'h2B);
        exp_q.push_back(8'h57);
        send_byte(8'h57);
        wait_drain("t1_drain");
        chk("t1_frame_err", fe_cnt, 0);
        chk("t1_overrun",   ov_cnt, 0);

        // T2: 10-cycle low glitch is rejected, next frame still received
        uart_rx = 1'b0;
        idle(10);
        uart_rx = 1'b1;
        idle(100);
        chk("t2_no_push",  int'(rd_valid), 0);
        chk("t2_no_error", fe_cnt, 0);
        exp_q.push_back(8'h3C);
        send_byte(8'h3C);
        wait_drain("t2_drain");

        // T3: stop bit low, line stays low 5 more bit times -> one framing error
        send_frame(8'h65, 1'b0);
        idle(5 * CLK_DIV);
        uart_rx = 1'b1;
        idle(100);
        chk("t3_frame_err", fe_cnt, 1);
        chk("t3_empty",     int'(rd_valid), 0);

        // T4: consumer stalled, fifth byte overruns
        rd_ready = 1'b0;
        for (int b = 1; b <= 5; b++) begin
            if (b <= 4) exp_q.push_back(8'(b));
            send_byte(8'(b));
            idle(5);
        end
        chk("t4_overrun", ov_cnt, 1);
        chk("t4_valid",   int'(rd_valid), 1);
        chk("t4_head",    int'(rd_data), 8'h01);
        rd_ready = 1'b1;
        wait_drain("t4_drain");
        rd_ready = 1'b0;

        // T5: pop in the exact cycle a push meets a full FIFO
        exp_q.push_back(8'h11); send_byte(8'h11);
        exp_q.push_back(8'h22); send_byte(8'h22);
        exp_q.push_back(8'h33); send_byte(8'h33);
        exp_q.push_back(8'h44); send_byte(8'h44);
        chk("t5_full_head", int'(rd_data), 8'h11);
        exp_q.push_back(8'h55);
        fork
            send_byte(8'h55);
            begin
                @(posedge clk);
                repeat (PUSH_OFS - 1) @(posedge clk);
                #1 rd_ready = 1'b1;
                @(posedge clk);
                #1 rd_ready = 1'b0;
            end
        join
        idle(5);
        chk("t5_no_overrun", ov_cnt, 1);
        chk("t5_head",       int'(rd_data), 8'h22);
        chk("t5_pending",    exp_q.size(), 4);
        rd_ready = 1'b1;
        wait_drain("t5_drain");

`ifdef UART_RX_PARITY_EN
        // T6: wrong parity discarded, correct parity pushed
        par_flip_g = 1'b1;
        send_byte(8'h6C);
        idle(10);
        chk("t6_parity_err", pe_cnt, 1);
        chk("t6_no_push",    int'(rd_valid), 0);
        par_flip_g = 1'b0;
        exp_q.push_back(8'h6F);
        send_byte(8'h6F);
        wait_drain("t6_drain");
        chk("t6_parity_once", pe_cnt, 1);
`endif

        // T7: reset mid-frame with line held low across release
        rd_ready = 1'b0;
        send_byte(8'h99);
        idle(5);
        chk("t7_pre_valid", int'(rd_valid), 1);
        uart_rx = 1'b0;
        idle(200);
        rst_n = 1'b0;
        idle(3);
        chk("t7_flush_valid", int'(rd_valid), 0);
        chk("t7_flush_data",  int'(rd_data), 0);
        rst_n = 1'b1;
        idle(5 * CLK_DIV);
        chk("t7_no_frame",     int'(rd_valid), 0);
        chk("t7_no_frame_err", fe_cnt, 1);
        uart_rx = 1'b1;
        idle(20);
        rd_ready = 1'b1;
        exp_q.push_back(8'h7E);
        send_byte(8'h7E);
        wait_drain("t7_drain");
        chk("end_frame_err", fe_cnt, 1);
        chk("end_overrun",   ov_cnt, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
